// File: rtl/output_fpga_pkg.sv
// Shared types and constants for the output-side seven-segment display block.
package output_fpga_pkg;

    localparam int DATA_W     = 17;
    localparam int DIGITS     = 6;
    localparam int ITERATIONS = 17;
    localparam int BCD_W      = 4 * DIGITS;
    localparam int SR_W       = BCD_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        UPDATE
    } state_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    // One shift-and-add-3 step over the combined {bcd, magnitude} register.
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] t;
        t = sr;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (t[DATA_W + 4*i +: 4] >= 4'd5)
                t[DATA_W + 4*i +: 4] = t[DATA_W + 4*i +: 4] + 4'd3;
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/output_fpga_seg7_encoder.sv
// Combinational BCD digit to active-low gfedcba segment pattern.
module seg7_encoder
    import output_fpga_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/output_fpga.sv
// Accepts a result word, converts it to BCD serially and drives six
// active-low seven-segment displays with optional sign and zero blanking.
module output_fpga
    import output_fpga_pkg::*;
#(
    parameter int SIGNED      = 0,
    parameter int BLANK_ZEROS = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] Data,
    input  logic              out_valid,
    output logic              out_ready,
    output logic [6:0]        HEX0,
    output logic [6:0]        HEX1,
    output logic [6:0]        HEX2,
    output logic [6:0]        HEX3,
    output logic [6:0]        HEX4,
    output logic [6:0]        HEX5
);

    state_t            state;
    logic [BCD_W-1:0]  bcd;
    logic [DATA_W-1:0] mag;
    logic [4:0]        cnt;
    logic              sign;
    logic [6:0]        hex_q [DIGITS];

    logic              neg_in;
    logic [DATA_W-1:0] mag_in;
    logic [6:0]        seg   [DIGITS];
    logic [6:0]        hex_n [DIGITS];
    logic [DIGITS-1:0] nz;

    assign out_ready = (state == IDLE);
    assign neg_in    = (SIGNED != 0) && Data[DATA_W-1];
    assign mag_in    = neg_in ? (~Data + 1'b1) : Data;

    for (genvar g = 0; g < DIGITS; g++) begin : g_enc
        seg7_encoder u_enc (
            .digit (bcd[4*g +: 4]),
            .seg   (seg[g])
        );
    end

    // nz[k] is set when digit k or any digit above it is non-zero.
    always_comb begin
        nz = '0;
        nz[DIGITS-1] = (bcd[BCD_W-1 -: 4] != 4'd0);
        for (int unsigned k = DIGITS - 1; k > 0; k--)
            nz[k-1] = nz[k] | (bcd[4*(k-1) +: 4] != 4'd0);
        for (int unsigned k = 0; k < DIGITS; k++)
            hex_n[k] = ((BLANK_ZEROS != 0) && (k != 0) && !nz[k]) ? SEG_BLANK : seg[k];
        if (SIGNED != 0)
            hex_n[DIGITS-1] = sign ? SEG_MINUS : SEG_BLANK;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            bcd   <= '0;
            mag   <= '0;
            cnt   <= '0;
            sign  <= 1'b0;
            for (int unsigned k = 0; k < DIGITS; k++)
                hex_q[k] <= SEG_BLANK;
        end else begin
            case (state)
                IDLE: begin
                    if (out_valid) begin
                        mag   <= mag_in;
                        sign  <= neg_in;
                        bcd   <= '0;
                        cnt   <= '0;
                        state <= CONVERT;
                    end
                end
                CONVERT: begin
                    {bcd, mag} <= dabble_step({bcd, mag});
                    if (cnt == 5'(ITERATIONS - 1)) begin
                        state <= UPDATE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                UPDATE: begin
                    for (int unsigned k = 0; k < DIGITS; k++)
                        hex_q[k] <= hex_n[k];
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_output_fpga.sv
// Scoreboard bench for output_fpga: three instances covering unsigned with
// blanking, unsigned without blanking, and signed with blanking.
module tb_output_fpga;

    localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

    typedef struct {
        logic [41:0] h;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [16:0] data  [3];
    logic        valid [3];
    logic        rdy   [3];
    logic [6:0]  hs    [3][6];

    int   cyc = 0;
    logic rst_q = 1'b1;
    logic started = 1'b0;
    int   checks = 0;
    int   errors = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    logic [41:0] last [3];
    logic        prev_rdy [3];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        output_fpga #(
            .SIGNED      (g == 2 ? 1 : 0),
            .BLANK_ZEROS (g == 1 ? 0 : 1)
        ) u_dut (
            .clock     (clk),
            .reset     (reset),
            .Data      (data[g]),
            .out_valid (valid[g]),
            .out_ready (rdy[g]),
            .HEX0      (hs[g][0]),
            .HEX1      (hs[g][1]),
            .HEX2      (hs[g][2]),
            .HEX3      (hs[g][3]),
            .HEX4      (hs[g][4]),
            .HEX5      (hs[g][5])
        );
    end

    function automatic logic [41:0] pk(input logic [6:0] h5, h4, h3, h2, h1, h0);
        return {h5, h4, h3, h2, h1, h0};
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Monitor: an out_ready rise marks a finished update (or an aborted one).
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                logic [41:0] cur;
                exp_t e;
                cur = {hs[i][5], hs[i][4], hs[i][3], hs[i][2], hs[i][1], hs[i][0]};
                if (prev_rdy[i] === 1'b0 && rdy[i] === 1'b1) begin
                    checks++;
                    if (qsize(i) == 0) begin
                        errors++;
                        $display("FAIL unexpected_update inst%0d: got %h, required no update", i, cur);
                    end else begin
                        case (i)
                            0: e = q0.pop_front();
                            1: e = q1.pop_front();
                            default: e = q2.pop_front();
                        endcase
                        if (cur !== e.h || (cyc - e.acc) != e.lat) begin
                            errors++;
                            $display("FAIL update inst%0d: got hex %h after %0d edges, required %h after %0d",
                                     i, cur, cyc - e.acc, e.h, e.lat);
                        end
                        last[i] = e.h;
                    end
                end else if (rst_q) begin
                    checks++;
                    if (cur !== ALL_BLANK || rdy[i] !== 1'b1) begin
                        errors++;
                        $display("FAIL reset inst%0d: got hex %h ready %b, required %h ready 1",
                                 i, cur, rdy[i], ALL_BLANK);
                    end
                    last[i] = ALL_BLANK;
                end else begin
                    checks++;
                    if (cur !== last[i]) begin
                        errors++;
                        $display("FAIL hold inst%0d cyc %0d: got %h, required %h", i, cyc, cur, last[i]);
                    end
                end
                prev_rdy[i] = rdy[i];
            end
        end
    end

    task automatic push(input int i, input logic [41:0] h, input int acc, input int lat);
        exp_t e;
        e.h = h; e.acc = acc; e.lat = lat;
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic send(input int i, input logic [16:0] d, input logic [41:0] h,
                        input int lat, output int acc);
        int n = 0;
        acc = -1;
        while (rdy[i] !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout inst%0d: got ready %b, required 1", i, rdy[i]);
        end else begin
            data[i]  = d;
            valid[i] = 1'b1;
            @(posedge clk); #1;
            valid[i] = 1'b0;
            acc = cyc;
            push(i, h, acc, lat);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending, required 0", q0.size() + q1.size() + q2.size());
        end
    endtask

    initial begin
        int a, a42, a99;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data[i] = '0; valid[i] = 1'b0; last[i] = ALL_BLANK; prev_rdy[i] = 1'b1;
        end
        @(posedge clk); #1;
        started = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        send(0, 17'd1234,  pk(7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19), 18, a);
        send(1, 17'd1234,  pk(7'h40, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19), 18, a);
        send(2, 17'h1FFFF, pk(7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79), 18, a);
        send(0, 17'd131071, pk(7'h79, 7'h30, 7'h79, 7'h40, 7'h78, 7'h79), 18, a);
        send(1, 17'd0,     pk(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40), 18, a);
        send(2, 17'h10000, pk(7'h3F, 7'h02, 7'h12, 7'h12, 7'h30, 7'h02), 18, a);
        send(0, 17'd0,     pk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40), 18, a);
        send(1, 17'd100000, pk(7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40), 18, a);
        send(2, 17'h0FFFF, pk(7'h7F, 7'h02, 7'h12, 7'h12, 7'h30, 7'h12), 18, a);
        send(0, 17'd100,   pk(7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40), 18, a);
        send(2, 17'd42,    pk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24), 18, a);
        drain();

        // A second value offered mid-conversion must be dropped.
        send(0, 17'd42, pk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24), 18, a42);
        repeat (4) @(posedge clk);
        #1 data[0] = 17'd99; valid[0] = 1'b1;
        @(posedge clk);
        #1 valid[0] = 1'b0;
        send(0, 17'd99, pk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10, 7'h10), 18, a99);
        checks++;
        if (a99 - a42 != 19) begin
            errors++;
            $display("FAIL throughput: got accept spacing %0d, required 19", a99 - a42);
        end
        drain();

        // Reset ten edges after accept aborts the conversion.
        send(0, 17'd777, ALL_BLANK, 10, a);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (q0.size() != 0 || rdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort: got pending %0d ready %b, required 0 and 1", q0.size(), rdy[0]);
        end

        // Reset and out_valid on the same edge: nothing accepted.
        data[0] = 17'd5; valid[0] = 1'b1; reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; valid[0] = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        checks++;
        if (rdy[0] !== 1'b1 || hs[0][0] !== 7'h7F) begin
            errors++;
            $display("FAIL reset_vs_valid: got ready %b hex0 %h, required 1 and 7f", rdy[0], hs[0][0]);
        end

        drain();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
